ecg_bcd_display_mux: RTL and testbench

- Parametrised successor to the ECG per-metric 7-segment display stage.
- Converts NUM_CH unsigned ECG statistics into NUM_DIG-digit 7-segment codes each. Typical statistics: average rate, beat count, clean beats, min/max threshold violations.
- Uses one shared sequential double-dabble engine instead of per-channel divide/modulo logic.
- Sits between the statistics block and the board display drivers. All channels commit together, so displays never tear.

---
 rtl/ecg_bcd_display_mux_pkg.sv | 58 +++++
 rtl/ecg_bcd_display_mux_if.sv | 23 ++
 rtl/ecg_bcd_display_mux_bcd_shift_add3.sv | 29 ++
 rtl/ecg_bcd_display_mux.sv | 141 ++++++++++++++
 tb/tb_ecg_bcd_display_mux.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecg_bcd_display_mux_pkg.sv
// ============================================================================
// ecg_display_pkg : FSM states, 7-segment constants and helpers for the
//                   ECG BCD display multiplexer.  Revision 1.0
// ============================================================================
`default_nettype none

package ecg_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Segment order {a,b,c,d,e,f,g}, a is the MSB.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Decimal digit count of 2^val_w - 1.
  function automatic int calc_bcd_dig(input int val_w);
    longint unsigned v;
    int n;
    v = (64'd1 << val_w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      4'd9:    return SEG_DIGIT[9];
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecg_bcd_display_mux_if.sv
// ============================================================================
// ecg_bcd_display_mux_if : refresh request, packed values and segment outputs
//                          between the statistics block and the display mux.
// Revision 1.0
// ============================================================================
`default_nettype none

interface ecg_bcd_display_mux_if #(
  parameter int NUM_CH  = 5,
  parameter int VAL_W   = 8,
  parameter int NUM_DIG = 3
);
  logic                          displaying;
  logic [NUM_CH*VAL_W-1:0]       values;
  logic [NUM_CH*NUM_DIG*7-1:0]   seg;
  logic                          busy;
  logic                          update_done;

  modport master (output displaying, values, input seg, busy, update_done);
  modport slave  (input displaying, values, output seg, busy, update_done);
endinterface

`default_nettype wire

// File: rtl/ecg_bcd_display_mux_bcd_shift_add3.sv
// ============================================================================
// bcd_shift_add3 : one combinational double-dabble step (add-3, then shift).
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_shift_add3 #(
  parameter int BCD_DIG = 3,
  parameter int VAL_W   = 8
) (
  input  logic [BCD_DIG*4-1:0] bcd_in,
  input  logic [VAL_W-1:0]     bin_in,
  output logic [BCD_DIG*4-1:0] bcd_out,
  output logic [VAL_W-1:0]     bin_out
);
  logic [BCD_DIG*4-1:0]       w_adj;
  logic [BCD_DIG*4+VAL_W-1:0] w_shift;

  for (genvar i = 0; i < BCD_DIG; i++) begin : g_nib
    assign w_adj[i*4 +: 4] = (bcd_in[i*4 +: 4] >= 4'd5) ? bcd_in[i*4 +: 4] + 4'd3
                                                        : bcd_in[i*4 +: 4];
  end

  assign w_shift = {w_adj, bin_in} << 1;
  assign {bcd_out, bin_out} = w_shift;

endmodule

`default_nettype wire

// File: rtl/ecg_bcd_display_mux.sv
// ============================================================================
// ecg_bcd_display_mux : shared double-dabble converter driving NUM_CH x NUM_DIG
//                       7-segment digits, all channels committed together.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision 1.0
// ============================================================================
`default_nettype none

module ecg_bcd_display_mux
  import ecg_display_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int VAL_W   = 8,
  parameter int NUM_DIG = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ecg_bcd_display_mux_if.slave bus
);
  localparam int BCD_DIG  = calc_bcd_dig(VAL_W);
  localparam int PAD_DIG  = (BCD_DIG > NUM_DIG) ? BCD_DIG : NUM_DIG;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W    = $clog2(VAL_W + 1);
  localparam int CH_SEG_W = NUM_DIG * 7;
  localparam int SEG_W    = NUM_CH * CH_SEG_W;

  state_t                r_state, w_state_nxt;
  logic [NUM_CH*VAL_W-1:0] r_snap;
  logic [CH_W-1:0]       r_ch;
  logic [BCD_DIG*4-1:0]  r_bcd, w_bcd_sh;
  logic [VAL_W-1:0]      r_shreg, w_shreg_sh;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [SEG_W-1:0]      r_shadow, w_shadow_nxt, r_seg;
  logic [PAD_DIG*4-1:0]  w_bcd_ext;
  logic [CH_SEG_W-1:0]   w_code;
  logic                  w_ovf, w_last, w_busy, w_done;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  w_upper_zero;
`endif

  bcd_shift_add3 #(.BCD_DIG(BCD_DIG), .VAL_W(VAL_W)) u_step (
    .bcd_in  (r_bcd),
    .bin_in  (r_shreg),
    .bcd_out (w_bcd_sh),
    .bin_out (w_shreg_sh)
  );

  assign w_last = (r_ch == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.displaying) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_bitcnt == CNT_W'(1)) w_state_nxt = ST_STORE;
      ST_STORE: w_state_nxt = w_last ? ST_DONE : ST_LOAD;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
    w_done = (r_state == ST_DONE);
  end

  // Digits above the BCD width read as zero; digits above NUM_DIG flag overflow.
  assign w_bcd_ext = (PAD_DIG*4)'(r_bcd);
  assign w_ovf     = |(w_bcd_ext >> (NUM_DIG*4));

  always_comb begin
    w_code = '0;
`ifdef LEADING_ZERO_BLANK_EN
    w_upper_zero = 1'b1;
`endif
    for (int d = NUM_DIG - 1; d >= 0; d--) begin
      w_code[d*7 +: 7] = seg7_encode(w_bcd_ext[d*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && w_upper_zero && w_bcd_ext[d*4 +: 4] == 4'd0)
        w_code[d*7 +: 7] = SEG_BLANK;
      w_upper_zero = w_upper_zero && (w_bcd_ext[d*4 +: 4] == 4'd0);
`endif
      if (w_ovf) w_code[d*7 +: 7] = SEG_DASH;
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[r_ch*CH_SEG_W +: CH_SEG_W] = w_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap   <= '0;
      r_ch     <= '0;
      r_bcd    <= '0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_shadow <= '0;
      r_seg    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.displaying) begin
            r_snap <= bus.values;
            r_ch   <= '0;
          end
        end
        ST_LOAD: begin
          r_bcd    <= '0;
          r_shreg  <= r_snap[r_ch*VAL_W +: VAL_W];
          r_bitcnt <= CNT_W'(VAL_W);
        end
        ST_SHIFT: begin
          r_bcd    <= w_bcd_sh;
          r_shreg  <= w_shreg_sh;
          r_bitcnt <= r_bitcnt - CNT_W'(1);
        end
        ST_STORE: begin
          r_shadow <= w_shadow_nxt;
          // The last channel commits the whole shadow at once so displays never tear.
          if (w_last) r_seg <= w_shadow_nxt;
          else        r_ch  <= r_ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.seg         = r_seg;
  assign bus.busy        = w_busy;
  assign bus.update_done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_ecg_bcd_display_mux.sv
// ============================================================================
// tb_ecg_bcd_display_mux : directed self-checking bench for the display mux.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ecg_bcd_display_mux;
  localparam int NUM_CH = 5;
  localparam int VAL_W  = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ecg_bcd_display_mux_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .NUM_DIG(3)) bus ();
  ecg_bcd_display_mux_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .NUM_DIG(2)) bus2 ();

  ecg_bcd_display_mux #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .NUM_DIG(3)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  ecg_bcd_display_mux #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .NUM_DIG(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dig_code(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [20:0] exp_chan(input int val, input int ndig);
    logic [20:0] r;
    int v;
    int lim;
    r = '0;
    v = val;
    lim = 1;
    for (int i = 0; i < ndig; i++) lim = lim * 10;
    for (int d = 0; d < ndig; d++) begin
      logic [6:0] c;
      c = dig_code(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && v == 0) c = 7'b0000000;
`endif
      if (val >= lim) c = 7'b0000001;
      r[d*7 +: 7] = c;
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] pack5(input int a, input int b, input int c,
                                        input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Ticks until update_done is seen on the chosen instance; -1 on timeout.
  task automatic wait_done(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((which == 0 && bus.update_done) || (which == 1 && bus2.update_done)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    bus.displaying = 1'b0;  bus.values = '0;
    bus2.displaying = 1'b0; bus2.values = '0;
    tick(); tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.update_done || bus2.update_done) pulses++;
    end
    checks++; if (bus.seg !== '0) begin failures++; $display("FAIL reset_seg: got %h expected 0", bus.seg); end
    checks++; if (bus2.seg !== '0) begin failures++; $display("FAIL reset_seg2: got %h expected 0", bus2.seg); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_done_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_convert();
    int v [5] = '{0, 7, 45, 128, 255};
    int n;
    bus.values = pack5(v[0], v[1], v[2], v[3], v[4]);
    bus.displaying = 1'b1;
    tick();
    bus.displaying = 1'b0;
    wait_done(0, 60, n);
    checks++; if (n !== 50) begin failures++; $display("FAIL convert_latency: got %0d expected 50", n); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (bus.seg[k*21 +: 21] !== exp_chan(v[k], 3)) begin
        failures++;
        $display("FAIL convert_ch%0d: got %h expected %h", k, bus.seg[k*21 +: 21], exp_chan(v[k], 3));
      end
    end
    tick();
    checks++; if (bus.update_done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b expected 0", bus.update_done); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (bus.seg[k*21 +: 21] !== exp_chan(v[k], 3)) begin
        failures++;
        $display("FAIL hold_ch%0d: got %h expected %h", k, bus.seg[k*21 +: 21], exp_chan(v[k], 3));
      end
    end
  endtask

  task automatic test_snapshot();
    int a [5] = '{1, 2, 3, 4, 5};
    int n;
    bus.values = pack5(a[0], a[1], a[2], a[3], a[4]);
    bus.displaying = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    bus.values = pack5(99, 99, 99, 99, 99);
    wait_done(0, 60, n);
    checks++; if (n !== 40) begin failures++; $display("FAIL snap_first_latency: got %0d expected 40", n); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (bus.seg[k*21 +: 21] !== exp_chan(a[k], 3)) begin
        failures++;
        $display("FAIL snap_old_ch%0d: got %h expected %h", k, bus.seg[k*21 +: 21], exp_chan(a[k], 3));
      end
    end
    wait_done(0, 70, n);
    bus.displaying = 1'b0;
    checks++; if (n !== 52) begin failures++; $display("FAIL snap_period: got %0d expected 52", n); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (bus.seg[k*21 +: 21] !== exp_chan(99, 3)) begin
        failures++;
        $display("FAIL snap_new_ch%0d: got %h expected %h", k, bus.seg[k*21 +: 21], exp_chan(99, 3));
      end
    end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL snap_stop_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_overflow();
    int v [5] = '{100, 99, 255, 9, 0};
    int n;
    bus2.values = pack5(v[0], v[1], v[2], v[3], v[4]);
    bus2.displaying = 1'b1;
    tick();
    bus2.displaying = 1'b0;
    wait_done(1, 60, n);
    checks++; if (n !== 50) begin failures++; $display("FAIL ovf_latency: got %0d expected 50", n); end
    for (int k = 0; k < NUM_CH; k++) begin
      logic [20:0] e;
      e = exp_chan(v[k], 2);
      checks++;
      if (bus2.seg[k*14 +: 14] !== e[13:0]) begin
        failures++;
        $display("FAIL ovf_ch%0d: got %h expected %h", k, bus2.seg[k*14 +: 14], e[13:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v [5] = '{200, 150, 3, 60, 11};
    int n;
    bus.values = pack5(12, 34, 56, 78, 90);
    bus.displaying = 1'b1;
    tick();
    bus.displaying = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.seg !== '0) begin failures++; $display("FAIL rstmid_seg: got %h expected 0", bus.seg); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.update_done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", bus.update_done); end
    reset = 1'b0;
    tick();
    bus.values = pack5(v[0], v[1], v[2], v[3], v[4]);
    bus.displaying = 1'b1;
    tick();
    bus.displaying = 1'b0;
    wait_done(0, 60, n);
    checks++; if (n !== 50) begin failures++; $display("FAIL rstmid_latency: got %0d expected 50", n); end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (bus.seg[k*21 +: 21] !== exp_chan(v[k], 3)) begin
        failures++;
        $display("FAIL rstmid_ch%0d: got %h expected %h", k, bus.seg[k*21 +: 21], exp_chan(v[k], 3));
      end
    end
    tick();
  endtask

  task automatic test_throughput();
    int pulses [$];
    bit busy_hist [201];
    int lows;
    int n;
    bus.values = pack5(1, 22, 133, 244, 55);
    bus.displaying = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      busy_hist[c] = bus.busy;
      if (bus.update_done) pulses.push_back(c);
    end
    bus.displaying = 1'b0;
    checks++; if (pulses.size() !== 3) begin failures++; $display("FAIL tput_pulses: got %0d expected 3", pulses.size()); end
    if (pulses.size() >= 2) begin
      for (int i = 0; i + 1 < pulses.size(); i++) begin
        checks++;
        if (pulses[i+1] - pulses[i] !== 52) begin
          failures++;
          $display("FAIL tput_period%0d: got %0d expected 52", i, pulses[i+1] - pulses[i]);
        end
        lows = 0;
        for (int c = pulses[i] + 1; c < pulses[i+1]; c++) if (!busy_hist[c]) lows++;
        checks++;
        if (lows !== 1) begin failures++; $display("FAIL tput_idle_gap%0d: got %0d expected 1", i, lows); end
      end
    end
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!bus.busy) begin n = i; break; end
    end
    checks++; if (n < 0) begin failures++; $display("FAIL tput_drain: busy still high after 60 cycles"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_convert();
    test_snapshot();
    test_overflow();
    test_reset_mid();
    test_throughput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
